wb_trace_monitor: RTL and testbench

WB_TRACE_MONITOR -- requirements
Module: wb_trace_monitor

---
 rtl/wb_trace_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_wb_trace_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor: watches a core's PC and register writeback port,
// detects program completion (PC stuck) or a watchdog timeout, gathers
// retire/write statistics and queues traced writes in a show-ahead FIFO.
module wb_trace_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RA_W        = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned MAX_CYCLES  = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] write_back_data,
  input  logic [RA_W-1:0] rd_addr,
  input  logic            regWrite,
  input  logic            trace_rd_en,
  output logic            trace_valid,
  output logic [XLEN-1:0] trace_pc,
  output logic [RA_W-1:0] trace_rd,
  output logic [XLEN-1:0] trace_data,
  output logic            trace_overflow,
  output logic            program_completed,
  output logic            timeout,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retire_count,
  output logic [31:0]     write_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  localparam int unsigned NW = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] prev_pc_q, prev_pc_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [NW-1:0]   cycle_q, cycle_d;
  logic [NW-1:0]   retire_q, retire_d;
  logic [NW-1:0]   write_q, write_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            tout_q, tout_d;

  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [RA_W-1:0] mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];

  logic clear_c;
  logic push_req_c;
  logic push_ok_c;
  logic pop_c;
  logic full_c;

  // Next-state: FSM, statistics and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    prev_pc_d  = prev_pc_q;
    stall_d    = stall_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    write_d    = write_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    clear_c    = 1'b0;
    push_req_c = 1'b0;
    push_ok_c  = 1'b0;
    full_c     = (count_q == CW'(DEPTH));
    pop_c      = trace_rd_en && (count_q != '0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          prev_pc_d = pc;
          stall_d   = '0;
          cycle_d   = '0;
          retire_d  = '0;
          write_d   = '0;
          ovf_d     = 1'b0;
          clear_c   = 1'b1;
        end
      end
      S_RUN: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + NW'(1);
          if (pc != prev_pc_q) begin
            retire_d = retire_q + NW'(1);
            stall_d  = '0;
          end else begin
            stall_d = stall_q + SW'(1);
          end
          prev_pc_d = pc;
          if (regWrite && (rd_addr != '0)) begin
            push_req_c = 1'b1;
            write_d    = write_q + NW'(1);
          end
          // Completion has priority over the watchdog on a tie
          if (stall_d == SW'(STALL_LIMIT)) begin
            state_d = S_DONE;
          end else if (cycle_d == NW'(MAX_CYCLES)) begin
            state_d = S_TIMEOUT;
          end
        end
      end
      default: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (clear_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A push into a full FIFO only survives if a pop frees a slot this cycle
      push_ok_c = push_req_c && (!full_c || pop_c);
      if (push_req_c && full_c && !pop_c) begin
        ovf_d = 1'b1;
      end
      if (push_ok_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    done_d = (state_d == S_DONE);
    tout_d = (state_d == S_TIMEOUT);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      prev_pc_q <= '0;
      stall_q   <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
      write_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_pc_q <= prev_pc_d;
      stall_q   <= stall_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      write_q   <= write_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
    end
  end

  // Trace storage; validity is tracked by the occupancy count, not the array
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_pc_q[wr_ptr_q]   <= pc;
      mem_rd_q[wr_ptr_q]   <= rd_addr;
      mem_data_q[wr_ptr_q] <= write_back_data;
    end
  end

  assign trace_valid       = (count_q != '0);
  assign trace_pc          = mem_pc_q[rd_ptr_q];
  assign trace_rd          = mem_rd_q[rd_ptr_q];
  assign trace_data        = mem_data_q[rd_ptr_q];
  assign trace_overflow    = ovf_q;
  assign program_completed = done_q;
  assign timeout           = tout_q;
  assign cycle_count       = cycle_q;
  assign retire_count      = retire_q;
  assign write_count       = write_q;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Bench for wb_trace_monitor: directed scenarios followed by a random phase,
// all compared against a queue-based reference model.
module tb_wb_trace_monitor;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RA_W        = 5;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned STALL_LIMIT = 8;
  localparam int unsigned MAX_CYCLES  = 64;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_TOUT = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } rec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic [RA_W-1:0] rd_addr = '0;
  logic            reg_write = 1'b0;
  logic            rd_en = 1'b0;
  logic            trace_valid;
  logic [XLEN-1:0] trace_pc;
  logic [RA_W-1:0] trace_rd;
  logic [XLEN-1:0] trace_data;
  logic            trace_overflow;
  logic            program_completed;
  logic            timeout;
  logic [31:0]     cycle_count;
  logic [31:0]     retire_count;
  logic [31:0]     write_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_mode = M_IDLE;
  logic [31:0] m_prev = '0;
  int          m_stall = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;
  logic [31:0] m_wr = '0;
  bit          m_ovf = 1'b0;
  rec_t        m_q[$];

  wb_trace_monitor #(
    .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH),
    .STALL_LIMIT(STALL_LIMIT), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .write_back_data(wb_data), .rd_addr(rd_addr), .regWrite(reg_write),
    .trace_rd_en(rd_en), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_rd(trace_rd), .trace_data(trace_data),
    .trace_overflow(trace_overflow), .program_completed(program_completed),
    .timeout(timeout), .cycle_count(cycle_count),
    .retire_count(retire_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_prev = '0; m_stall = 0;
    m_cyc = '0; m_ret = '0; m_wr = '0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  // Apply one clock edge of behaviour to the model using the current inputs
  task automatic model_step();
    bit pop;
    bit push;
    pop  = rd_en && (m_q.size() != 0);
    push = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (start) begin
          m_mode = M_RUN; m_prev = pc; m_stall = 0;
          m_cyc = '0; m_ret = '0; m_wr = '0; m_ovf = 1'b0;
          m_q.delete();
          pop = 1'b0;
        end
      end
      M_RUN: begin
        if (!start) begin
          m_mode = M_IDLE;
        end else begin
          if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
          if (pc != m_prev) begin m_ret++; m_stall = 0; end
          else m_stall++;
          m_prev = pc;
          if (reg_write && rd_addr != 0) begin push = 1'b1; m_wr++; end
          if (m_stall == int'(STALL_LIMIT)) m_mode = M_DONE;
          else if (m_cyc == MAX_CYCLES) m_mode = M_TOUT;
        end
      end
      default: if (!start) m_mode = M_IDLE;
    endcase
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back('{pc: pc, rd: rd_addr, data: wb_data});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(trace_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("head_pc", 64'(trace_pc), 64'(m_q[0].pc));
      chk("head_rd", 64'(trace_rd), 64'(m_q[0].rd));
      chk("head_data", 64'(trace_data), 64'(m_q[0].data));
    end
    chk("overflow", 64'(trace_overflow), 64'(m_ovf));
    chk("completed", 64'(program_completed), 64'(m_mode == M_DONE));
    chk("timeout", 64'(timeout), 64'(m_mode == M_TOUT));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("retire_count", 64'(retire_count), 64'(m_ret));
    chk("write_count", 64'(write_count), 64'(m_wr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int          n;
    logic [31:0] last;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_valid", 64'(trace_valid), 64'd0);
    reset = 1'b1;

    // Program runs 10 instructions then freezes
    start = 1'b1; pc = 32'h100;
    tick();
    for (int k = 1; k <= 10; k++) begin
      pc = 32'h100 + 32'(4 * k);
      tick();
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) chk("t038_not_yet", 64'(program_completed), 64'd0);
    end
    chk("t038_done", 64'(program_completed), 64'd1);
    chk("t038_retire", 64'(retire_count), 64'd10);
    chk("t038_cycles", 64'(cycle_count), 64'd18);
    start = 1'b0;
    tick();
    chk("t038_idle", 64'(program_completed), 64'd0);

    // Single traced write and an ignored write to x0
    start = 1'b1; pc = 32'h10;
    tick();
    reg_write = 1'b1; rd_addr = 5'd2; wb_data = 32'd25;
    tick();
    rd_addr = 5'd0; wb_data = 32'd99; pc = 32'h14;
    tick();
    reg_write = 1'b0;
    chk("t039_valid", 64'(trace_valid), 64'd1);
    chk("t039_pc", 64'(trace_pc), 64'h10);
    chk("t039_rd", 64'(trace_rd), 64'd2);
    chk("t039_data", 64'(trace_data), 64'd25);
    chk("t039_wcount", 64'(write_count), 64'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t039_one_entry", 64'(trace_valid), 64'd0);
    start = 1'b0;
    tick();

    // Overflow: 17 writes into a 16-entry FIFO
    start = 1'b1; pc = 32'h0;
    tick();
    for (int i = 0; i < 17; i++) begin
      reg_write = 1'b1; rd_addr = 5'(i % 31 + 1);
      wb_data = 32'h1000 + 32'(i); pc = 32'(4 * (i + 1));
      tick();
    end
    reg_write = 1'b0;
    chk("t040_ovf", 64'(trace_overflow), 64'd1);
    chk("t040_wcount", 64'(write_count), 64'd17);
    start = 1'b0;
    tick();
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t040_order", 64'(trace_data), 64'(32'h1000 + 32'(i)));
      tick();
    end
    rd_en = 1'b0;
    chk("t040_empty", 64'(trace_valid), 64'd0);
    chk("t040_ovf_sticky", 64'(trace_overflow), 64'd1);

    // Full FIFO with simultaneous push and pop
    start = 1'b1; pc = 32'h0;
    tick();
    for (int i = 0; i < 16; i++) begin
      reg_write = 1'b1; rd_addr = 5'd3;
      wb_data = 32'h2000 + 32'(i); pc = 32'(4 * (i + 1));
      tick();
    end
    chk("t041_full_no_ovf", 64'(trace_overflow), 64'd0);
    chk("t041_oldest", 64'(trace_data), 64'h2000);
    rd_addr = 5'd7; wb_data = 32'hABCD; pc = 32'h100; rd_en = 1'b1;
    tick();
    reg_write = 1'b0; rd_en = 1'b0;
    chk("t041_ovf", 64'(trace_overflow), 64'd0);
    chk("t041_next", 64'(trace_data), 64'h2001);
    start = 1'b0;
    tick();
    n = 0; last = '0;
    rd_en = 1'b1;
    for (int i = 0; i < 40 && trace_valid; i++) begin
      last = trace_data;
      n++;
      tick();
    end
    rd_en = 1'b0;
    chk("t041_occupancy", 64'(n), 64'd16);
    chk("t041_last", 64'(last), 64'hABCD);

    // Watchdog with a toggling PC
    start = 1'b1; pc = 32'h0;
    tick();
    for (int i = 1; i <= 64; i++) begin
      pc = (i % 2 == 1) ? 32'h4 : 32'h0;
      tick();
      if (i == 63) chk("t042_not_yet", 64'(timeout), 64'd0);
    end
    chk("t042_timeout", 64'(timeout), 64'd1);
    chk("t042_not_done", 64'(program_completed), 64'd0);
    chk("t042_cycles", 64'(cycle_count), 64'd64);
    pc = 32'h4;
    tick();
    chk("t042_hold", 64'(cycle_count), 64'd64);
    start = 1'b0;
    tick();

    // Asynchronous reset mid-run with queued records
    start = 1'b1; pc = 32'h0;
    tick();
    for (int i = 0; i < 5; i++) begin
      reg_write = 1'b1; rd_addr = 5'(i + 1);
      wb_data = 32'h500 + 32'(i); pc = 32'(4 * (i + 1));
      tick();
    end
    reg_write = 1'b0;
    chk("t043_queued", 64'(trace_valid), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t043_valid", 64'(trace_valid), 64'd0);
    chk("t043_cycles", 64'(cycle_count), 64'd0);
    chk("t043_retire", 64'(retire_count), 64'd0);
    chk("t043_writes", 64'(write_count), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk("t043_via_idle", 64'(cycle_count), 64'd0);
    tick();
    chk("t043_running", 64'(cycle_count), 64'd1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 2) == 0) pc = 32'($urandom_range(0, 7) * 4);
      reg_write = 1'($urandom_range(0, 1));
      rd_addr = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      rd_en = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
